// File: rtl/avalon_line_queue.sv
// avalon_line_queue: Avalon-MM command queue feeding a line draw engine.
// Build option ALQ_IRQ_EN adds the irq port and the IRQCTL register.
module avalon_line_queue #(
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
  input  logic [2:0]    address,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          waitrequest,
  output logic          start,
  input  logic          done,
  output logic [XW-1:0] x0,
  output logic [XW-1:0] x1,
  output logic [YW-1:0] y0,
  output logic [YW-1:0] y1,
  output logic [CW-1:0] colour
`ifdef ALQ_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [XW-1:0] ex;
    logic [YW-1:0] ey;
    logic [CW-1:0] col;
  } cmd_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic          mode_q;
  logic          ovf_q;
  logic [XW-1:0] s_sx;
  logic [YW-1:0] s_sy;
  logic [XW-1:0] s_ex;
  logic [YW-1:0] s_ey;
  logic [CW-1:0] s_col;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] lvl_d;

  logic          sel_mode;
  logic          sel_status;
  logic          sel_go;
  logic          sel_start;
  logic          sel_end;
  logic          sel_col;
  logic          sel_irq;

  logic          go;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          go_block;
  logic          flush;
  logic          ovf_clr;
  cmd_t          head;
  cmd_t          push_cmd;
  logic          unused;

  assign sel_mode   = (address == 3'd0);
  assign sel_status = (address == 3'd1);
  assign sel_go     = (address == 3'd2);
  assign sel_start  = (address == 3'd3);
  assign sel_end    = (address == 3'd4);
  assign sel_col    = (address == 3'd5);
  assign sel_irq    = (address == 3'd6);

  assign go       = write && sel_go;
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign go_block = go && full && !pop;
  assign push     = go && !go_block;
  assign flush    = write && sel_status && writedata[0];
  assign ovf_clr  = write && sel_status && writedata[3];

  assign waitrequest = go_block && !mode_q;
  assign start       = (state_q == RUN);
  assign head        = mem[rd_ptr];
  assign push_cmd    = {s_sx, s_sy, s_ex, s_ey, s_col};
  assign unused      = ^{read, writedata};

  // dispatch state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // dispatch next state: pop the head when idle, wait for done when running
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // next queue level; flush wins, but the entry popped this cycle still runs
  always_comb begin
    lvl_d = level;
    if (flush) begin
      lvl_d = '0;
    end else if (push && !pop) begin
      lvl_d = level + LW'(1);
    end else if (pop && !push) begin
      lvl_d = level - LW'(1);
    end
  end

  // queue storage, no reset needed since level gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  // queue pointers and level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= lvl_d;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // engine command outputs, loaded on pop and held through RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0     <= '0;
      y0     <= '0;
      x1     <= '0;
      y1     <= '0;
      colour <= '0;
    end else if (pop) begin
      x0     <= head.sx;
      y0     <= head.sy;
      x1     <= head.ex;
      y1     <= head.ey;
      colour <= head.col;
    end
  end

  // control registers: mode, overflow and staging
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
      s_sx   <= '0;
      s_sy   <= '0;
      s_ex   <= '0;
      s_ey   <= '0;
      s_col  <= '0;
    end else begin
      if (go_block && mode_q) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (write) begin
        unique case (1'b1)
          sel_mode: mode_q <= writedata[0];
          sel_start: begin
            s_sx <= writedata[XW-1:0];
            s_sy <= writedata[XW+YW-1:XW];
          end
          sel_end: begin
            s_ex <= writedata[XW-1:0];
            s_ey <= writedata[XW+YW-1:XW];
          end
          sel_col: s_col <= writedata[CW-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef ALQ_IRQ_EN
  logic ien_q;
  logic pend_q;
  logic pend_set;

  assign pend_set = (state_q == RUN) && done && (lvl_d == '0);
  assign irq      = pend_q && ien_q;

  // drained interrupt: pending on last completion, cleared by IRQCTL bit1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ien_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      if (write && sel_irq) begin
        ien_q <= writedata[0];
      end
      if (pend_set) begin
        pend_q <= 1'b1;
      end else if (write && sel_irq && writedata[1]) begin
        pend_q <= 1'b0;
      end
    end
  end
`endif

  // combinational read mux
  always_comb begin
    readdata = '0;
    unique case (1'b1)
      sel_mode: readdata = {31'b0, mode_q};
      sel_status: begin
        readdata[0]    = !empty || (state_q == RUN);
        readdata[1]    = full;
        readdata[2]    = empty;
        readdata[3]    = ovf_q;
        readdata[15:8] = 8'(level);
      end
      sel_go:    readdata = '0;
      sel_start: readdata = 32'({s_sy, s_sx});
      sel_end:   readdata = 32'({s_ey, s_ex});
      sel_col:   readdata = 32'(s_col);
`ifdef ALQ_IRQ_EN
      sel_irq:   readdata = {30'b0, pend_q, ien_q};
`else
      sel_irq:   readdata = '0;
`endif
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_avalon_line_queue.sv
// tb_avalon_line_queue: random and directed bench for avalon_line_queue
// against a queue-based reference model.
module tb_avalon_line_queue;

  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int CW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [2:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic          done = 1'b0;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic          start;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;
  logic [CW-1:0] colour;
`ifdef ALQ_IRQ_EN
  logic          irq;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int sx;
    int sy;
    int ex;
    int ey;
    int col;
  } ent_t;

  ent_t mq[$];
  ent_t m_cur;
  bit   m_run;
  bit   m_mode;
  bit   m_ovf;
  bit   m_pend;
  bit   m_ien;
  int   s_sx;
  int   s_sy;
  int   s_ex;
  int   s_ey;
  int   s_col;
  logic [31:0] last_rd;

  avalon_line_queue #(
    .XW(XW),
    .YW(YW),
    .CW(CW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .write(write),
    .address(address),
    .writedata(writedata),
    .readdata(readdata),
    .waitrequest(waitrequest),
    .start(start),
    .done(done),
    .x0(x0),
    .x1(x1),
    .y0(y0),
    .y1(y1),
    .colour(colour)
`ifdef ALQ_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    int lvl;
    lvl = mq.size();
    case (a)
      3'd0: return 32'(m_mode);
      3'd1: return 32'((lvl << 8) | (int'(m_ovf) << 3) |
                       (int'(lvl == 0) << 2) | (int'(lvl == DEPTH) << 1) |
                       int'(m_run || lvl != 0));
      3'd3: return 32'((s_sy << XW) | s_sx);
      3'd4: return 32'((s_ey << XW) | s_ex);
      3'd5: return 32'(s_col);
`ifdef ALQ_IRQ_EN
      3'd6: return 32'((int'(m_pend) << 1) | int'(m_ien));
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cur  = '{0, 0, 0, 0, 0};
    m_run  = 0;
    m_mode = 0;
    m_ovf  = 0;
    m_pend = 0;
    m_ien  = 0;
    s_sx   = 0;
    s_sy   = 0;
    s_ex   = 0;
    s_ey   = 0;
    s_col  = 0;
  endtask

  // one bus cycle: drive, check at negedge, advance model at posedge
  task automatic step(input logic rd, input logic wr, input logic [2:0] a,
                      input logic [31:0] wd, input logic dn,
                      output bit stl);
    bit   pop;
    bit   full;
    bit   blk;
    bit   fin;
    ent_t e;
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    done      = dn;
    pop  = !m_run && mq.size() > 0;
    full = mq.size() == DEPTH;
    blk  = wr && a == 3'd2 && full && !pop;
    stl  = blk && !m_mode;
    @(negedge clk);
    chk("waitrequest", 32'(waitrequest), 32'(stl));
    chk("start", 32'(start), 32'(m_run));
    chk("start_pt", 32'({y0, x0}), 32'((m_cur.sy << XW) | m_cur.sx));
    chk("end_pt", 32'({y1, x1}), 32'((m_cur.ey << XW) | m_cur.ex));
    chk("colour", 32'(colour), 32'(m_cur.col));
`ifdef ALQ_IRQ_EN
    chk("irq", 32'(irq), 32'(m_pend && m_ien));
`endif
    if (rd) begin
      last_rd = readdata;
      chk("readdata", readdata, model_read(a));
    end
    @(posedge clk);
    fin = 0;
    if (pop) begin
      m_cur = mq.pop_front();
      m_run = 1;
    end else if (m_run && dn) begin
      m_run = 0;
      fin   = 1;
    end
    if (wr) begin
      case (a)
        3'd0: m_mode = wd[0];
        3'd1: begin
          if (wd[0]) mq.delete();
          if (wd[3]) m_ovf = 0;
        end
        3'd2: begin
          if (blk) begin
            if (m_mode) m_ovf = 1;
          end else begin
            e = '{s_sx, s_sy, s_ex, s_ey, s_col};
            mq.push_back(e);
          end
        end
        3'd3: begin
          s_sx = int'(wd[XW-1:0]);
          s_sy = int'(wd[XW+YW-1:XW]);
        end
        3'd4: begin
          s_ex = int'(wd[XW-1:0]);
          s_ey = int'(wd[XW+YW-1:XW]);
        end
        3'd5: s_col = int'(wd[CW-1:0]);
`ifdef ALQ_IRQ_EN
        3'd6: begin
          m_ien = wd[0];
          if (wd[1]) m_pend = 0;
        end
`endif
        default: ;
      endcase
    end
`ifdef ALQ_IRQ_EN
    if (fin && mq.size() == 0) m_pend = 1;
`endif
    #1;
  endtask

  task automatic idle(input int n, input logic dn);
    bit s;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, dn, s);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bit s;
    step(1'b0, 1'b1, a, d, 1'b0, s);
  endtask

  task automatic rd(input logic [2:0] a);
    bit s;
    step(1'b1, 1'b0, a, 32'd0, 1'b0, s);
  endtask

  // GO write held while stalled; done pulses on iteration dn_at
  task automatic go(input int dn_at, output int stalls);
    bit s;
    int n;
    n = 0;
    stalls = 0;
    do begin
      step(1'b0, 1'b1, 3'd2, 32'd0, n == dn_at, s);
      if (s) stalls++;
      n++;
    end while (s && n < 200);
    if (n >= 200) chk("go_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    read  = 1'b0;
    write = 1'b0;
    done  = 1'b0;
    reset = 1'b0;
    #2;
    chk("reset_start", 32'(start), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int r;
    bit s;
    model_clear();
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;

    rd(3'd1);
    chk("reset_status", last_rd, 32'h4);

    wr(3'd3, 32'h0A05);
    wr(3'd4, 32'h14028);
    wr(3'd5, 32'd5);
    go(-1, st);
    idle(2, 1'b0);
    chk("dir_start", 32'(start), 32'd1);
    chk("dir_x0y0", 32'({x0, y0}), 32'({9'd5, 8'd5}));
    chk("dir_x1y1", 32'({x1, y1}), 32'({9'd40, 8'd160}));
    chk("dir_col", 32'(colour), 32'd5);
    idle(1, 1'b1);
    chk("dir_stop", 32'(start), 32'd0);
    rd(3'd1);
    chk("dir_empty", 32'(last_rd[2]), 32'd1);

    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) go(-1, st);
    go(3, st);
    chk("stall_seen", 32'(st > 0), 32'd1);
    rd(3'd1);
    chk("stall_level", 32'(last_rd[15:8]), 32'd4);

    do_reset();
    wr(3'd0, 32'd1);
    for (int i = 0; i < DEPTH + 2; i++) go(-1, st);
    rd(3'd1);
    chk("poll_ovf", 32'(last_rd[3]), 32'd1);
    chk("poll_level", 32'(last_rd[15:8]), 32'd4);
    wr(3'd1, 32'h8);
    rd(3'd1);
    chk("ovf_clr", 32'(last_rd[3]), 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) go(-1, st);
    wr(3'd1, 32'h1);
    rd(3'd1);
    chk("flush_level", 32'(last_rd[15:8]), 32'd0);
    idle(3, 1'b0);
    chk("flush_inflight", 32'(start), 32'd1);
    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("flush_idle", 32'(start), 32'd0);

    go(-1, st);
    idle(2, 1'b0);
    chk("pre_reset_run", 32'(start), 32'd1);
    do_reset();
    rd(3'd1);
    chk("post_reset_status", last_rd, 32'h4);

`ifdef ALQ_IRQ_EN
    wr(3'd6, 32'd1);
    go(-1, st);
    go(-1, st);
    idle(1, 1'b1);
    chk("irq_first", 32'(irq), 32'd0);
    idle(1, 1'b0);
    idle(1, 1'b1);
    chk("irq_second", 32'(irq), 32'd1);
    wr(3'd6, 32'h2);
    chk("irq_clr", 32'(irq), 32'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30) begin
        go($urandom_range(0, 5), st);
      end else if (r < 45) begin
        wr(3'($urandom_range(3, 5)), $urandom);
      end else if (r < 57) begin
        rd(3'($urandom_range(0, 7)));
      end else if (r < 60) begin
        wr(3'd0, $urandom & 32'h1);
      end else if (r < 63) begin
        wr(3'd1, $urandom & 32'h9);
      end else if (r < 66) begin
        wr(3'($urandom_range(6, 7)), $urandom);
      end else if (r < 67) begin
        do_reset();
      end else begin
        step(1'b0, 1'b0, 3'd0, 32'd0, $urandom_range(0, 2) == 0, s);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
